// File: rtl/quant_act_pkg.sv
// Shared types, reset defaults and arithmetic helpers for quant_act_combine.
package quant_act_pkg;

  typedef enum logic [1:0] {
    MODE_LIN   = 2'd0,
    MODE_RELU  = 2'd1,
    MODE_LEAKY = 2'd2
  } mode_e;

  localparam logic [15:0] DEF_M0   = 16'd31316;
  localparam logic [5:0]  DEF_SH0  = 6'd25;
  localparam logic [15:0] DEF_MP   = 16'd30419;
  localparam logic [5:0]  DEF_SHP  = 6'd14;
  localparam logic [15:0] DEF_MN   = 16'd24335;
  localparam logic [5:0]  DEF_SHN  = 6'd17;
  localparam int          DEF_ZP   = 12;
  localparam mode_e       DEF_MODE = MODE_LEAKY;

  function automatic logic signed [63:0] sat_s(
    input logic signed [63:0] v,
    input int unsigned        w
  );
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  // Round half up: add 2^(sh-1) before the arithmetic shift.
  function automatic logic signed [63:0] rshift_round(
    input logic signed [63:0] v,
    input logic        [5:0]  sh
  );
    logic signed [63:0] r;
    r = v;
    if (sh != 6'd0) r = v + (64'sd1 <<< (sh - 6'd1));
    return r >>> sh;
  endfunction

endpackage

// File: rtl/quant_act_combine_requant_mul_shift.sv
// Signed x unsigned multiply, rounding right shift, saturate to OW bits.
module requant_mul_shift #(
  parameter int IW = 19,
  parameter int OW = 16
) (
  input  logic signed [IW-1:0] x,
  input  logic        [15:0]   m,
  input  logic        [5:0]    sh,
  output logic signed [OW-1:0] y
);
  import quant_act_pkg::*;

  localparam int PW = IW + 17;

  logic signed [PW-1:0] p;

  always_comb begin
    p = PW'(x) * PW'($signed({1'b0, m}));
    y = OW'(sat_s(rshift_round(64'(p), sh), OW));
  end

endmodule

// File: rtl/quant_act_combine.sv
// Sum per-filter partials plus bias, requantise, activate, add zero-point.
// Three registered stages under one global stall, with framing counter.
module quant_act_combine #(
  parameter int C   = 3,
  parameter int F   = 2,
  parameter int AW  = 16,
  parameter int OW  = 16,
  parameter int FCW = 20
) (
  input  logic              clk,
  input  logic              Rst,
  input  logic [C*F*AW-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              cfg_load,
  input  logic [F*AW-1:0]   cfg_bias,
  input  logic [15:0]       cfg_m0,
  input  logic [5:0]        cfg_sh0,
  input  logic [15:0]       cfg_mp,
  input  logic [5:0]        cfg_shp,
  input  logic [15:0]       cfg_mn,
  input  logic [5:0]        cfg_shn,
  input  logic [OW-1:0]     cfg_zp,
  input  logic [1:0]        cfg_mode,
  input  logic [FCW-1:0]    cfg_frame_len,
  output logic              cfg_err,
  output logic [F*OW-1:0]   out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last
);
  import quant_act_pkg::*;

  localparam int SW = AW + $clog2(C) + 1;

  logic [F*SW-1:0]      s1_q, s1_d;
  logic [F*OW-1:0]      q2_q, q2_d, q2_w;
  logic [F*OW-1:0]      ap_w, an_w;
  logic [F*OW-1:0]      out_data_q, out_data_d;
  logic                 v1_q, v1_d, v2_q, v2_d;
  logic                 out_valid_q, out_valid_d;
  logic                 err_q, err_d;
  logic [F*AW-1:0]      bias_q, bias_d;
  logic [15:0]          m0_q, m0_d, mp_q, mp_d, mn_q, mn_d;
  logic [5:0]           sh0_q, sh0_d, shp_q, shp_d, shn_q, shn_d;
  logic signed [OW-1:0] zp_q, zp_d;
  logic [1:0]           mode_q, mode_d;
  logic [FCW-1:0]       fl_q, fl_d, cnt_q, cnt_d, fl_eff;
  logic                 en, acc, idle, cfg_ok, last;
  logic signed [SW-1:0] sum;
  logic signed [OW-1:0] qv, av;

  for (genvar f = 0; f < F; f++) begin : g_f
    requant_mul_shift #(.IW(SW), .OW(OW)) u_rq (
      .x (s1_q[f*SW +: SW]),
      .m (m0_q),
      .sh(sh0_q),
      .y (q2_w[f*OW +: OW])
    );
    requant_mul_shift #(.IW(OW), .OW(OW)) u_pos (
      .x (q2_q[f*OW +: OW]),
      .m (mp_q),
      .sh(shp_q),
      .y (ap_w[f*OW +: OW])
    );
    requant_mul_shift #(.IW(OW), .OW(OW)) u_neg (
      .x (q2_q[f*OW +: OW]),
      .m (mn_q),
      .sh(shn_q),
      .y (an_w[f*OW +: OW])
    );
  end

  always_comb begin
    en     = !out_valid_q || out_ready;
    acc    = in_valid && en;
    idle   = !v1_q && !v2_q && !out_valid_q && !acc;
    cfg_ok = cfg_load && idle;
    fl_eff = (fl_q == '0) ? FCW'(1) : fl_q;
    last   = cnt_q == fl_eff - FCW'(1);

    v1_d        = v1_q;
    v2_d        = v2_q;
    out_valid_d = out_valid_q;
    s1_d        = s1_q;
    q2_d        = q2_q;
    out_data_d  = out_data_q;
    sum         = '0;
    qv          = '0;
    av          = '0;

    if (en) begin
      v1_d        = in_valid;
      v2_d        = v1_q;
      out_valid_d = v2_q;
    end
    if (en && v1_q) q2_d = q2_w;

    for (int f = 0; f < F; f++) begin
      sum = SW'($signed(bias_q[f*AW +: AW]));
      for (int c = 0; c < C; c++)
        sum = sum + SW'($signed(in_data[(f*C+c)*AW +: AW]));
      if (acc) s1_d[f*SW +: SW] = sum;

      qv = $signed(q2_q[f*OW +: OW]);
      case (mode_q)
        MODE_RELU:  av = qv[OW-1] ? '0 : qv;
        MODE_LEAKY: av = qv[OW-1] ? $signed(an_w[f*OW +: OW])
                                  : $signed(ap_w[f*OW +: OW]);
        default:    av = qv;
      endcase
      if (en && v2_q)
        out_data_d[f*OW +: OW] = OW'(sat_s(64'(av) + 64'(zp_q), OW));
    end

    bias_d = bias_q;
    m0_d   = m0_q;
    sh0_d  = sh0_q;
    mp_d   = mp_q;
    shp_d  = shp_q;
    mn_d   = mn_q;
    shn_d  = shn_q;
    zp_d   = zp_q;
    mode_d = mode_q;
    fl_d   = fl_q;
    if (cfg_ok) begin
      bias_d = cfg_bias;
      m0_d   = cfg_m0;
      sh0_d  = cfg_sh0;
      mp_d   = cfg_mp;
      shp_d  = cfg_shp;
      mn_d   = cfg_mn;
      shn_d  = cfg_shn;
      zp_d   = cfg_zp;
      mode_d = cfg_mode;
      fl_d   = cfg_frame_len;
    end
    err_d = cfg_load && !idle;

    cnt_d = cnt_q;
    if (cfg_ok) cnt_d = '0;
    else if (out_valid_q && out_ready)
      cnt_d = last ? '0 : cnt_q + FCW'(1);
  end

  always_ff @(posedge clk) begin
    if (Rst) begin
      v1_q        <= 1'b0;
      v2_q        <= 1'b0;
      out_valid_q <= 1'b0;
      s1_q        <= '0;
      q2_q        <= '0;
      out_data_q  <= '0;
      err_q       <= 1'b0;
      cnt_q       <= '0;
      bias_q      <= '0;
      m0_q        <= DEF_M0;
      sh0_q       <= DEF_SH0;
      mp_q        <= DEF_MP;
      shp_q       <= DEF_SHP;
      mn_q        <= DEF_MN;
      shn_q       <= DEF_SHN;
      zp_q        <= OW'(DEF_ZP);
      mode_q      <= DEF_MODE;
      fl_q        <= FCW'(1);
    end else begin
      v1_q        <= v1_d;
      v2_q        <= v2_d;
      out_valid_q <= out_valid_d;
      s1_q        <= s1_d;
      q2_q        <= q2_d;
      out_data_q  <= out_data_d;
      err_q       <= err_d;
      cnt_q       <= cnt_d;
      bias_q      <= bias_d;
      m0_q        <= m0_d;
      sh0_q       <= sh0_d;
      mp_q        <= mp_d;
      shp_q       <= shp_d;
      mn_q        <= mn_d;
      shn_q       <= shn_d;
      zp_q        <= zp_d;
      mode_q      <= mode_d;
      fl_q        <= fl_d;
    end
  end

  assign in_ready  = en;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_valid_q && last;
  assign cfg_err   = err_q;

endmodule

// File: tb/tb_quant_act_combine.sv
// Directed bench for quant_act_combine: vector table plus stream,
// framing, config-rejection and reset sequences.
module tb_quant_act_combine;

  localparam int C = 3, F = 2, AW = 16, OW = 16, FCW = 20;

  logic              clk = 1'b0;
  logic              Rst;
  logic [C*F*AW-1:0] in_data;
  logic              in_valid, in_ready;
  logic              cfg_load;
  logic [F*AW-1:0]   cfg_bias;
  logic [15:0]       cfg_m0, cfg_mp, cfg_mn;
  logic [5:0]        cfg_sh0, cfg_shp, cfg_shn;
  logic [OW-1:0]     cfg_zp;
  logic [1:0]        cfg_mode;
  logic [FCW-1:0]    cfg_frame_len;
  logic              cfg_err;
  logic [F*OW-1:0]   out_data;
  logic              out_valid, out_ready, out_last;

  int nvec = 0;
  int nerr = 0;
  logic err1;

  typedef struct {
    logic [31:0] bias;
    logic [15:0] m0, mp, mn;
    logic [5:0]  sh0, shp, shn;
    logic [15:0] zp;
    logic [1:0]  mode;
    logic [19:0] fl;
  } cfg_t;

  typedef struct {
    cfg_t        c;
    logic [95:0] din;
    logic [31:0] exp;
  } vec_t;

  vec_t vt [9];

  quant_act_combine #(.C(C), .F(F), .AW(AW), .OW(OW), .FCW(FCW)) dut (
    .clk          (clk),
    .Rst          (Rst),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .cfg_load     (cfg_load),
    .cfg_bias     (cfg_bias),
    .cfg_m0       (cfg_m0),
    .cfg_sh0      (cfg_sh0),
    .cfg_mp       (cfg_mp),
    .cfg_shp      (cfg_shp),
    .cfg_mn       (cfg_mn),
    .cfg_shn      (cfg_shn),
    .cfg_zp       (cfg_zp),
    .cfg_mode     (cfg_mode),
    .cfg_frame_len(cfg_frame_len),
    .cfg_err      (cfg_err),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_last     (out_last)
  );

  always #5 clk = ~clk;

  function automatic logic [95:0] pk6(int a0, int a1, int a2,
                                      int b0, int b1, int b2);
    return {16'(b2), 16'(b1), 16'(b0), 16'(a2), 16'(a1), 16'(a0)};
  endfunction

  function automatic logic [31:0] pk2(int f0, int f1);
    return {16'(f1), 16'(f0)};
  endfunction

  function automatic cfg_t def_cfg();
    cfg_t c;
    c.bias = '0;
    c.m0   = 16'd31316;
    c.sh0  = 6'd25;
    c.mp   = 16'd30419;
    c.shp  = 6'd14;
    c.mn   = 16'd24335;
    c.shn  = 6'd17;
    c.zp   = 16'd12;
    c.mode = 2'd2;
    c.fl   = 20'd1;
    return c;
  endfunction

  function automatic cfg_t pass_cfg(int zp, int fl);
    cfg_t c;
    c      = def_cfg();
    c.m0   = 16'd1;
    c.sh0  = 6'd0;
    c.mode = 2'd0;
    c.zp   = 16'(zp);
    c.fl   = 20'(fl);
    return c;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic set_cfg(input cfg_t c);
    cfg_bias      = c.bias;
    cfg_m0        = c.m0;
    cfg_sh0       = c.sh0;
    cfg_mp        = c.mp;
    cfg_shp       = c.shp;
    cfg_mn        = c.mn;
    cfg_shn       = c.shn;
    cfg_zp        = c.zp;
    cfg_mode      = c.mode;
    cfg_frame_len = c.fl;
  endtask

  task automatic load_cfg(input cfg_t c);
    @(negedge clk);
    set_cfg(c);
    cfg_load = 1'b1;
    @(negedge clk);
    cfg_load = 1'b0;
    chk("cfg_idle_err", cfg_err, 0);
  endtask

  // Caller positions just after a negedge; frame length is 1 here.
  task automatic send_one(input logic [95:0] din, input logic [31:0] exp,
                          input string nm);
    int lat;
    in_valid = 1'b1;
    in_data  = din;
    @(negedge clk);
    in_valid = 1'b0;
    cfg_load = 1'b0;
    err1     = cfg_err;
    lat      = 1;
    while (!out_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    chk({nm, "_lat"}, lat, 3);
    chk({nm, "_data"}, out_data, exp);
    chk({nm, "_last"}, out_last, 1);
    @(negedge clk);
  endtask

  task automatic stream(input int n, input bit toggle, input int fl);
    int sent, recv;
    bit st;
    logic [31:0] hold_d;
    logic hold_l;
    sent = 0;
    recv = 0;
    st = 1'b0;
    hold_d = '0;
    hold_l = 1'b0;
    for (int cyc = 0; cyc < 200 && recv < n; cyc++) begin
      @(negedge clk);
      if (st) begin
        chk("stall_valid", out_valid, 1);
        chk("stall_data", out_data, hold_d);
        chk("stall_last", out_last, hold_l);
      end
      out_ready = toggle ? ((cyc / 2) % 2 == 0) : 1'b1;
      in_valid  = sent < n;
      in_data   = pk6(100 + sent, 1, 2, -(200 + sent), -1, -2);
      #1;
      chk("in_ready", in_ready, !out_valid || out_ready);
      if (out_valid && out_ready) begin
        chk("strm_data", out_data, pk2(103 + recv, -(203 + recv)));
        chk("strm_last", out_last, ((recv + 1) % fl) == 0);
        recv++;
      end
      st     = out_valid && !out_ready;
      hold_d = out_data;
      hold_l = out_last;
      if (in_valid && in_ready) sent++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    chk("strm_count", recv, n);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 9; i++) vt[i].c = def_cfg();
    vt[0].c.bias = pk2(-3845, 0);
    vt[0].din = pk6(1000, 2000, 3000, -10000, -10000, -10000);
    vt[0].exp = pk2(16, 7);
    vt[1] = vt[0];
    vt[1].c.mode = 2'd1;
    vt[1].exp = pk2(14, 12);
    vt[2].c = pass_cfg(12, 1);
    vt[2].c.m0 = 16'd65535;
    vt[2].din = pk6(32767, 32767, 32767, 32767, 32767, 32767);
    vt[2].exp = pk2(32767, 32767);
    vt[3] = vt[2];
    vt[3].c.zp = 16'(-5);
    vt[3].din = pk6(-32768, -32768, -32768, -32768, -32768, -32768);
    vt[3].exp = pk2(-32768, -32768);
    vt[4] = vt[0];
    vt[4].c.mode = 2'd3;
    vt[4].exp = pk2(14, -16);
    vt[5].c = pass_cfg(0, 1);
    vt[5].c.bias = pk2(0, 2);
    vt[5].din = pk6(5, -3, 7, -1, -1, -1);
    vt[5].exp = pk2(9, -1);
    vt[6].c = pass_cfg(0, 1);
    vt[6].c.sh0 = 6'd1;
    vt[6].din = pk6(1, 1, 1, -1, -1, -1);
    vt[6].exp = pk2(2, -1);
    vt[7].c = pass_cfg(0, 1);
    vt[7].c.mode = 2'd2;
    vt[7].c.mp = 16'd3;
    vt[7].c.shp = 6'd1;
    vt[7].c.mn = 16'd1;
    vt[7].c.shn = 6'd2;
    vt[7].din = pk6(2, 2, 1, -2, -2, -2);
    vt[7].exp = pk2(8, -1);
    vt[8].c = pass_cfg(100, 1);
    vt[8].din = pk6(10900, 10900, 10900, -10900, -10900, -10900);
    vt[8].exp = pk2(32767, -32600);

    Rst = 1'b1;
    in_valid = 1'b0;
    in_data = '0;
    cfg_load = 1'b0;
    out_ready = 1'b1;
    set_cfg(def_cfg());
    repeat (2) @(negedge clk);
    Rst = 1'b0;
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_last", out_last, 0);
    chk("rst_err", cfg_err, 0);
    chk("rst_ready", in_ready, 1);

    for (int i = 0; i < 9; i++) begin
      load_cfg(vt[i].c);
      @(negedge clk);
      send_one(vt[i].din, vt[i].exp, $sformatf("vec%0d", i));
    end

    load_cfg(pass_cfg(0, 2));
    stream(8, 1'b1, 2);
    load_cfg(pass_cfg(0, 3));
    stream(7, 1'b0, 3);
    load_cfg(pass_cfg(0, 0));
    stream(3, 1'b0, 1);

    load_cfg(pass_cfg(0, 1));
    @(negedge clk);
    in_valid = 1'b1;
    in_data = pk6(10, 20, 30, -1, -2, -3);
    @(negedge clk);
    in_valid = 1'b0;
    set_cfg(pass_cfg(500, 1));
    cfg_load = 1'b1;
    @(negedge clk);
    cfg_load = 1'b0;
    chk("mid_err", cfg_err, 1);
    @(negedge clk);
    chk("mid_err_pulse", cfg_err, 0);
    chk("mid_valid", out_valid, 1);
    chk("mid_data", out_data, pk2(60, -6));
    @(negedge clk);

    set_cfg(pass_cfg(500, 1));
    cfg_load = 1'b1;
    send_one(pk6(10, 20, 30, -1, -2, -3), pk2(60, -6), "simul");
    chk("simul_err", err1, 1);

    load_cfg(pass_cfg(500, 1));
    @(negedge clk);
    send_one(pk6(10, 20, 30, -1, -2, -3), pk2(560, 494), "idle_load");

    @(negedge clk);
    in_valid = 1'b1;
    in_data = pk6(1, 1, 1, 1, 1, 1);
    @(negedge clk);
    in_data = pk6(2, 2, 2, 2, 2, 2);
    @(negedge clk);
    in_valid = 1'b0;
    Rst = 1'b1;
    chk("inflight_valid", out_valid, 0);
    @(negedge clk);
    Rst = 1'b0;
    chk("rst2_valid", out_valid, 0);
    chk("rst2_data", out_data, 0);
    chk("rst2_last", out_last, 0);
    chk("rst2_ready", in_ready, 1);
    repeat (4) begin
      @(negedge clk);
      chk("rst2_quiet", out_valid, 0);
    end
    @(negedge clk);
    send_one(pk6(1000, 2000, 3000, -10000, -10000, -10000),
             pk2(23, 7), "post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
